// File: rtl/mem_bus_arbiter_if.sv
// Purpose: bundles both master ports, the shared slave port and arbiter status
//          of mem_bus_arbiter into one interface.
// Ports (signals):
//   m0_*/m1_* : read (ren/raddr -> rvalid/rdata) and write (wen/waddr/wdata/wstrb
//               -> wready) handshakes per master, plus err on timeout completion
//   s_*       : single-outstanding slave read/write bus
//   busy/owner: transaction in flight, current or last grantee
// Modports: slave  = arbiter view (masters' requests in, slave requests out)
//           master = environment view (drives requests and slave responses)
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              m0_ren;
  logic [ADDR_W-1:0] m0_raddr;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_wen;
  logic [ADDR_W-1:0] m0_waddr;
  logic [DATA_W-1:0] m0_wdata;
  logic [STRB_W-1:0] m0_wstrb;
  logic              m0_wready;
  logic              m0_err;

  logic              m1_ren;
  logic [ADDR_W-1:0] m1_raddr;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_wen;
  logic [ADDR_W-1:0] m1_waddr;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              m1_wready;
  logic              m1_err;

  logic              s_ren;
  logic [ADDR_W-1:0] s_raddr;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic              s_wen;
  logic [ADDR_W-1:0] s_waddr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wready;

  logic              busy;
  logic              owner;

  modport slave (
    input  m0_ren, m0_raddr, m0_wen, m0_waddr, m0_wdata, m0_wstrb,
    output m0_rvalid, m0_rdata, m0_wready, m0_err,
    input  m1_ren, m1_raddr, m1_wen, m1_waddr, m1_wdata, m1_wstrb,
    output m1_rvalid, m1_rdata, m1_wready, m1_err,
    output s_ren, s_raddr, s_wen, s_waddr, s_wdata, s_wstrb,
    input  s_rvalid, s_rdata, s_wready,
    output busy, owner
  );

  modport master (
    output m0_ren, m0_raddr, m0_wen, m0_waddr, m0_wdata, m0_wstrb,
    input  m0_rvalid, m0_rdata, m0_wready, m0_err,
    output m1_ren, m1_raddr, m1_wen, m1_waddr, m1_wdata, m1_wstrb,
    input  m1_rvalid, m1_rdata, m1_wready, m1_err,
    input  s_ren, s_raddr, s_wen, s_waddr, s_wdata, s_wstrb,
    output s_rvalid, s_rdata, s_wready,
    input  busy, owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one single-outstanding memory bus between
//          m0 (core data port) and m1 (debug/loader), grant locked per
//          transaction, with a timeout that completes hung accesses with err=1.
// Ports:
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   bus    : mem_bus_arbiter_if.slave (master handshakes, slave bus, busy/owner)
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic                clock,
  input logic                resetn,
  mem_bus_arbiter_if.slave   bus
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              w_owner_nxt;
  logic              r_last_owner;
  logic              w_last_owner_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_req0;
  logic              w_req1;
  logic              w_grant;
  logic              w_timeout;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;

  // Timeout fires on the last allowed busy cycle; a zero setting disables it.
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Arbitration, slave request mux and completion routing.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_cnt_nxt        = r_cnt;
    w_req0           = bus.m0_ren | bus.m0_wen;
    w_req1           = bus.m1_ren | bus.m1_wen;
    w_grant          = 1'b0;
    w_rd_done        = 1'b0;
    w_wr_done        = 1'b0;
    w_err            = 1'b0;
    w_rdata          = '0;
    bus.s_ren        = 1'b0;
    bus.s_raddr      = '0;
    bus.s_wen        = 1'b0;
    bus.s_waddr      = '0;
    bus.s_wdata      = '0;
    bus.s_wstrb      = '0;

    case (r_state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          // Tie goes to whoever did not win last time.
          w_grant          = (w_req0 && w_req1) ? ~r_last_owner : w_req1;
          w_owner_nxt      = w_grant;
          w_last_owner_nxt = w_grant;
          w_cnt_nxt        = '0;
          // Read has priority when a master raises ren and wen together.
          w_state_nxt      = (w_grant ? bus.m1_ren : bus.m0_ren) ? S_RD : S_WR;
        end
      end
      S_RD: begin
        bus.s_ren   = 1'b1;
        bus.s_raddr = ADDR_W'(r_owner ? bus.m1_raddr : bus.m0_raddr);
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (bus.s_rvalid) begin
          w_rd_done   = 1'b1;
          w_rdata     = DATA_W'(bus.s_rdata);
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_rd_done   = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        bus.s_wen   = 1'b1;
        bus.s_waddr = ADDR_W'(r_owner ? bus.m1_waddr : bus.m0_waddr);
        bus.s_wdata = DATA_W'(r_owner ? bus.m1_wdata : bus.m0_wdata);
        bus.s_wstrb = STRB_W'(r_owner ? bus.m1_wstrb : bus.m0_wstrb);
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (bus.s_wready) begin
          w_wr_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_wr_done   = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Completions go to the owner only; the other master sees zeros.
    bus.m0_rvalid = w_rd_done & ~r_owner;
    bus.m1_rvalid = w_rd_done &  r_owner;
    bus.m0_rdata  = r_owner ? '0 : w_rdata;
    bus.m1_rdata  = r_owner ? w_rdata : '0;
    bus.m0_wready = w_wr_done & ~r_owner;
    bus.m1_wready = w_wr_done &  r_owner;
    bus.m0_err    = w_err & ~r_owner;
    bus.m1_err    = w_err &  r_owner;
    bus.busy      = (r_state != S_IDLE);
    bus.owner     = r_owner;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single-outstanding memory bus (ren/raddr/rvalid/rdata, wen/waddr/wdata/wstrb/wready) between two masters: m0 = RiscV core data port, m1 = debug/loader port.
- Round-robin grant, locked per transaction, with a per-transaction timeout that completes hung accesses with an error flag.
- Sits between the core and the memory/peripheral slave in top.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 1024, busy cycles before forced completion; 0 disables the timeout
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mX_ren  in  1  read request, X in {0,1}; held until mX_rvalid
- mX_raddr  in  ADDR_W  read address; stable while mX_ren is high
- mX_rvalid  out  1  read completion pulse
- mX_rdata  out  DATA_W  read data, valid with mX_rvalid
- mX_wen  in  1  write request; held until mX_wready
- mX_waddr / mX_wdata  in  ADDR_W / DATA_W  write address and data; stable while mX_wen is high
- mX_wstrb  in  DATA_W/8  byte strobes
- mX_wready  out  1  write completion pulse
- mX_err  out  1  high with mX_rvalid or mX_wready when that completion was caused by timeout
- s_ren / s_raddr  out  1 / ADDR_W  slave read request
- s_rvalid / s_rdata  in  1 / DATA_W  slave read response
- s_wen / s_waddr / s_wdata / s_wstrb  out  slave write request
- s_wready  in  1  slave write accept
- busy  out  1  a transaction is in flight
- owner  out  1  current or last grantee

Behaviour:
- Reset (asynchronous, resetn=0):
  - State IDLE; last_owner=1, so m0 wins the first tie; timeout counter=0.
  - All outputs 0: s_ren, s_wen, s_* buses, mX_rvalid, mX_wready, mX_rdata, mX_err, busy, owner.
  - Reset during a transaction abandons it with no completion pulse; the slave sees s_ren/s_wen drop asynchronously.
- States:
  - IDLE: no transaction.
  - RD: read owned by `owner`.
  - WR: write owned by `owner`.
- IDLE arbitration:
  - A master requests when ren|wen is high.
  - One requester: that master is granted.
  - Both request: grant !last_owner.
  - A master asserting ren and wen together gets its read first; its wen stays pending.
  - On grant, register owner, set last_owner=owner and clear the counter. Next state is RD if the granted master's ren is high, else WR.
- RD:
  - s_ren=1; s_raddr muxed combinationally from the owner's raddr.
  - On s_rvalid=1: owner's rvalid=1 and rdata=s_rdata in the same cycle, err=0; next state IDLE.
- WR:
  - s_wen=1; s_waddr/s_wdata/s_wstrb muxed combinationally from the owner.
  - On s_wready=1: owner's wready=1, err=0; next state IDLE.
- Non-owner outputs: rvalid/wready/err/rdata held 0. rdata is 0 whenever rvalid is 0.
- Latency: grant decision in cycle N; s_ren/s_wen high from N+1; completion is combinational with the slave response.
- At least one IDLE cycle between transactions. Masters drop the request the cycle after completion, so no stale re-grant occurs.
- Timeout:
  - Counter increments each RD/WR cycle.
  - When TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 with no slave response: owner gets rvalid (rdata=0) or wready, with err=1; next state IDLE.
  - If the slave response and timeout coincide, the response wins and err=0.
  - A late s_rvalid/s_wready arriving in IDLE is ignored.
- busy=1 in RD/WR. owner holds its value in IDLE.
- Slave-side inputs are ignored outside the matching state.

Test Plan:
- Reset, then m0_ren=1 raddr=0x100; slave answers rvalid 2 cycles after s_ren with 0xCAFEF00D -> s_ren high cycles 1-3, m0_rvalid=1 m0_rdata=0xCAFEF00D m0_err=0 in cycle 3, busy drops cycle 4.
- m0_wen and m1_wen both held from reset, slave wready 1 cycle after s_wen -> grants alternate m0, m1, m0…; each wready goes only to its owner; s_waddr matches the owner's address.
- m1 asserts ren and wen together (0x20 / 0x24, wdata 0x55, wstrb 0x1) -> read completes first, then the write to 0x24 with s_wstrb=0x1.
- TIMEOUT_CYCLES=8, slave never responds to an m1 read -> m1_rvalid=1 m1_err=1 rdata=0 on the 8th busy cycle; a later s_rvalid is ignored; m0 is granted next.
- resetn pulsed low mid-write -> s_wen and all outputs 0 immediately; after release, a pending m1 request is granted only after m0 wins the tie (last_owner=1).
